// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension pipeline stage:
// extension mode encodings and skid-buffer state encoding.
package imm_ext_pkg;

  localparam logic [1:0] IMM_SEXT   = 2'b00;
  localparam logic [1:0] IMM_ZEXT   = 2'b01;
  localparam logic [1:0] IMM_UPPER  = 2'b10;
  localparam logic [1:0] IMM_BRANCH = 2'b11;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } skid_state_e;

endpackage

// File: rtl/imm_extend_core.sv
// Combinational immediate extender: maps a raw IN_WIDTH immediate and a
// 2-bit mode onto an OUT_WIDTH value (sign, zero, upper, branch offset).
module imm_extend_core
  import imm_ext_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32
) (
  input  logic [IN_WIDTH-1:0]  imm,
  input  logic [1:0]           mode,
  output logic [OUT_WIDTH-1:0] ext
);

  localparam int EXT_W = OUT_WIDTH - IN_WIDTH;

  logic [OUT_WIDTH-1:0] sext_s;

  assign sext_s = {{EXT_W{imm[IN_WIDTH-1]}}, imm};

  // Select the extension flavour; branch offsets are word-aligned sign extensions.
  always_comb begin
    ext = '0;
    case (mode)
      IMM_SEXT:   ext = sext_s;
      IMM_ZEXT:   ext = {{EXT_W{1'b0}}, imm};
      IMM_UPPER:  ext = {imm, {EXT_W{1'b0}}};
      IMM_BRANCH: ext = {sext_s[OUT_WIDTH-3:0], 2'b00};
      default:    ext = sext_s;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-extension stage with a valid/ready handshake through a
// main output register plus one skid register, and a synchronous flush.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Flush,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic [IN_WIDTH-1:0]  In_Imm,
  input  logic [1:0]           In_Mode,
  input  logic [TAG_WIDTH-1:0] In_Tag,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic [OUT_WIDTH-1:0] Out_Imm,
  output logic [TAG_WIDTH-1:0] Out_Tag
);

  if (OUT_WIDTH < IN_WIDTH + 2) begin : g_width_chk
    $fatal(1, "imm_extend_pipe: OUT_WIDTH must be >= IN_WIDTH+2");
  end

  skid_state_e          state_r, next_state_s;
  logic                 in_ready_r, out_valid_r;
  logic [OUT_WIDTH-1:0] main_imm_r, skid_imm_r, ext_s;
  logic [TAG_WIDTH-1:0] main_tag_r, skid_tag_r;
  logic                 in_xfer_s, out_xfer_s;
  logic                 load_main_s, load_skid_s, main_from_skid_s;

  imm_extend_core #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_core (
    .imm  (In_Imm),
    .mode (In_Mode),
    .ext  (ext_s)
  );

  assign in_xfer_s  = In_Valid && in_ready_r;
  assign out_xfer_s = out_valid_r && Out_Ready;

  // Next-state and storage-load decisions; flush overrides every transfer.
  always_comb begin
    next_state_s     = state_r;
    load_main_s      = 1'b0;
    load_skid_s      = 1'b0;
    main_from_skid_s = 1'b0;
    if (Flush) begin
      next_state_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_xfer_s) begin
            load_main_s  = 1'b1;
            next_state_s = ST_ONE;
          end else begin
            next_state_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_xfer_s && out_xfer_s) begin
            load_main_s  = 1'b1;
            next_state_s = ST_ONE;
          end else if (out_xfer_s) begin
            next_state_s = ST_EMPTY;
          end else if (in_xfer_s) begin
            load_skid_s  = 1'b1;
            next_state_s = ST_FULL;
          end else begin
            next_state_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_xfer_s) begin
            load_main_s      = 1'b1;
            main_from_skid_s = 1'b1;
            next_state_s     = ST_ONE;
          end else begin
            next_state_s = ST_FULL;
          end
        end
        default: next_state_s = ST_EMPTY;
      endcase
    end
  end

  // State, handshake flags and data storage; flags are precomputed from next state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r     <= ST_EMPTY;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      main_imm_r  <= '0;
      main_tag_r  <= '0;
      skid_imm_r  <= '0;
      skid_tag_r  <= '0;
    end else begin
      state_r     <= next_state_s;
      in_ready_r  <= (next_state_s != ST_FULL);
      out_valid_r <= (next_state_s != ST_EMPTY);
      if (load_main_s) begin
        main_imm_r <= main_from_skid_s ? skid_imm_r : ext_s;
        main_tag_r <= main_from_skid_s ? skid_tag_r : In_Tag;
      end
      if (load_skid_s) begin
        skid_imm_r <= ext_s;
        skid_tag_r <= In_Tag;
      end
    end
  end

  assign In_Ready  = in_ready_r;
  assign Out_Valid = out_valid_r;
  assign Out_Imm   = main_imm_r;
  assign Out_Tag   = main_tag_r;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: stimulus pushes expected results,
// a negedge monitor pops and compares on every output transfer.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [15:0] in_imm;
  logic [1:0]  in_mode;
  logic [4:0]  in_tag, out_tag;
  logic [31:0] out_imm;

  // 12->24 instance for the parameter sweep
  logic        p_valid, p_ready, p_out_valid;
  logic [11:0] p_imm;
  logic [1:0]  p_mode;
  logic [4:0]  p_tag, p_out_tag;
  logic [23:0] p_out_imm;

  typedef struct {
    logic [31:0] imm;
    logic [4:0]  tag;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  bit          hold_v = 1'b0;
  logic [31:0] hold_imm;
  logic [4:0]  hold_tag;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  imm_extend_pipe dut (
    .Clk(clk), .Reset_n(rst_n), .Flush(flush),
    .In_Valid(in_valid), .In_Ready(in_ready), .In_Imm(in_imm),
    .In_Mode(in_mode), .In_Tag(in_tag),
    .Out_Valid(out_valid), .Out_Ready(out_ready),
    .Out_Imm(out_imm), .Out_Tag(out_tag)
  );

  imm_extend_pipe #(.IN_WIDTH(12), .OUT_WIDTH(24), .TAG_WIDTH(5)) dut_p (
    .Clk(clk), .Reset_n(rst_n), .Flush(1'b0),
    .In_Valid(p_valid), .In_Ready(p_ready), .In_Imm(p_imm),
    .In_Mode(p_mode), .In_Tag(p_tag),
    .Out_Valid(p_out_valid), .Out_Ready(1'b1),
    .Out_Imm(p_out_imm), .Out_Tag(p_out_tag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [15:0] imm, input logic [1:0] mode,
                      input logic [4:0] tag, input logic [31:0] exp, input bit lat);
    bit done = 1'b0;
    in_valid = 1'b1; in_imm = imm; in_mode = mode; in_tag = tag;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{imm: exp, tag: tag, acc: cyc, lat: lat});
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  // Monitor: stability under backpressure, and scoreboard pop on each output transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v && out_valid) begin
        check("hold_imm", out_imm, hold_imm);
        check("hold_tag", {27'd0, out_tag}, {27'd0, hold_tag});
      end
      hold_v   = out_valid && !out_ready;
      hold_imm = out_imm;
      hold_tag = out_tag;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("out_imm", out_imm, e.imm);
          check("out_tag", {27'd0, out_tag}, {27'd0, e.tag});
          if (e.lat) check("latency", cyc, e.acc + 1);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_imm = 16'h0000; in_mode = 2'b00; in_tag = 5'd0;
    p_valid = 1'b0; p_imm = 12'h000; p_mode = 2'b00; p_tag = 5'd0;
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_imm", out_imm, 32'd0);
    check("rst_out_tag", {27'd0, out_tag}, 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Mode vectors
    send(16'h6424, 2'b00, 5'd10, 32'h00006424, 1'b1);
    send(16'h81C0, 2'b00, 5'd11, 32'hFFFF81C0, 1'b1);
    send(16'h81C0, 2'b01, 5'd12, 32'h000081C0, 1'b1);
    send(16'h81C0, 2'b10, 5'd13, 32'h81C00000, 1'b1);
    send(16'hFFFF, 2'b11, 5'd14, 32'hFFFFFFFC, 1'b1);
    repeat (3) @(posedge clk); #1;

    // Backpressure: tags 1,2 accepted, tag 3 held upstream
    out_ready = 1'b0;
    send(16'h0011, 2'b01, 5'd1, 32'h00000011, 1'b0);
    send(16'h0022, 2'b01, 5'd2, 32'h00000022, 1'b0);
    check("bp_ready_drop", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1; in_imm = 16'h0033; in_mode = 2'b01; in_tag = 5'd3;
    repeat (2) begin
      @(negedge clk);
      check("bp_hold_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(16'h0033, 2'b01, 5'd3, 32'h00000033, 1'b0);
    repeat (4) @(posedge clk); #1;
    check("bp_drained", sb.size(), 32'd0);

    // Streaming: 8 back-to-back, latency check proves no bubbles
    for (int i = 0; i < 8; i++)
      send(16'h8000 + 16'(i), 2'b00, 5'(16 + i), 32'hFFFF8000 + 32'(i), 1'b1);
    repeat (3) @(posedge clk); #1;

    // Flush while FULL
    out_ready = 1'b0;
    send(16'h0A0A, 2'b01, 5'd20, 32'h00000A0A, 1'b0);
    send(16'h0B0B, 2'b01, 5'd21, 32'h00000B0B, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_in_ready", {31'd0, in_ready}, 32'd1);
    sb.delete();
    out_ready = 1'b1;
    repeat (4) @(posedge clk); #1;

    // Async reset while FULL, mid-cycle
    out_ready = 1'b0;
    send(16'h0C0C, 2'b01, 5'd22, 32'h00000C0C, 1'b0);
    send(16'h0D0D, 2'b01, 5'd23, 32'h00000D0D, 1'b0);
    check("full_before_reset", {31'd0, in_ready}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("areset_out_valid", {31'd0, out_valid}, 32'd0);
    check("areset_in_ready", {31'd0, in_ready}, 32'd1);
    check("areset_out_imm", out_imm, 32'd0);
    sb.delete();
    out_ready = 1'b1;
    repeat (2) @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(posedge clk); #1;

    // Parameter sweep on 12->24 instance
    p_valid = 1'b1; p_imm = 12'h800; p_mode = 2'b00; p_tag = 5'd7;
    @(posedge clk); #1 p_valid = 1'b0;
    check("sweep_valid0", {31'd0, p_out_valid}, 32'd1);
    check("sweep_sext", {8'd0, p_out_imm}, 32'h00FFF800);
    check("sweep_tag", {27'd0, p_out_tag}, 32'd7);
    p_valid = 1'b1; p_mode = 2'b11; p_tag = 5'd8;
    @(posedge clk); #1 p_valid = 1'b0;
    check("sweep_valid1", {31'd0, p_out_valid}, 32'd1);
    check("sweep_branch", {8'd0, p_out_imm}, 32'h00FFE000);

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    check("final_sb_empty", sb.size(), 32'd0);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
